// File: rtl/usart_rx_monitor.sv
// Bus-mapped 16x-oversampled serial receiver with a 4-entry FIFO; frames land 3 cycles + stop-bit midpoint after the line,
// bus reads are combinational; no backpressure: a frame arriving into a full FIFO is dropped and flagged as DOR.
module usart_rx_monitor (
    input  logic        cp2,
    input  logic        ireset,
    input  logic [11:0] ram_Addr,
    input  logic        ramre,
    input  logic        ramwe,
    input  logic [7:0]  dbus_in,
    output logic [7:0]  dbus_out,
    output logic        out_en,
    input  logic        RxDn_i,
    output logic        RxcIRQ
);

    localparam logic [11:0] RxData_Address  = 12'h0D0;
    localparam logic [11:0] RxStat_Address  = 12'h0D1;
    localparam logic [11:0] RxCtrl_Address  = 12'h0D2;
    localparam logic [11:0] RxBaudL_Address = 12'h0D4;
    localparam logic [11:0] RxBaudH_Address = 12'h0D5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ctrl_q;
    logic [11:0] ubrr_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [11:0] presc_q, presc_d;
    logic [3:0]  os_q, os_d;
    logic [1:0]  samp_q, samp_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        pe_q, pe_d;
    logic [9:0]  fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        dor_q;

    logic sel_data, sel_stat, sel_ctrl, sel_baudl, sel_baudh;
    logic rd_data, pop, wr_ctrl, wr_stat, wr_baud, rx_disable;
    logic rxen, par_en, tick, fall, vote, decide, par_calc;
    logic push_req, push_ok, dor_set, nonempty;
    logic [2:0] last_bit;
    logic [9:0] head, entry;

    assign sel_data  = (ram_Addr == RxData_Address);
    assign sel_stat  = (ram_Addr == RxStat_Address);
    assign sel_ctrl  = (ram_Addr == RxCtrl_Address);
    assign sel_baudl = (ram_Addr == RxBaudL_Address);
    assign sel_baudh = (ram_Addr == RxBaudH_Address);

    assign rd_data    = ramre & sel_data;
    assign nonempty   = (count_q != 3'd0);
    assign pop        = rd_data & nonempty;
    assign wr_ctrl    = ramwe & sel_ctrl;
    assign wr_stat    = ramwe & sel_stat;
    assign wr_baud    = ramwe & (sel_baudl | sel_baudh);
    assign rx_disable = wr_ctrl & ctrl_q[7] & ~dbus_in[7];

    assign rxen     = ctrl_q[7];
    assign par_en   = ctrl_q[5];
    assign last_bit = 3'd4 + {1'b0, ctrl_q[2:1]};
    assign tick     = (presc_q == ubrr_q);
    assign fall     = rx_prev_q & ~rx_s2_q;
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
    assign decide   = tick & (os_q == 4'd9);
    // Unused upper data bits are zero, so the full-byte XOR is the data parity.
    assign par_calc = (^shreg_q) ^ ctrl_q[4];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        pe_d      = pe_q;
        push_req  = 1'b0;
        presc_d   = tick ? 12'd0 : presc_q + 12'd1;
        os_d      = tick ? os_q + 4'd1 : os_q;
        samp_d    = samp_q;
        if (tick && os_q == 4'd7) samp_d[0] = rx_s2_q;
        if (tick && os_q == 4'd8) samp_d[1] = rx_s2_q;

        case (state_q)
            IDLE: begin
                if (rxen && fall) begin
                    state_d   = START;
                    presc_d   = 12'd0;
                    os_d      = 4'd0;
                    bit_cnt_d = 3'd0;
                    shreg_d   = 8'd0;
                    pe_d      = 1'b0;
                end
            end
            START: begin
                if (decide) state_d = vote ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shreg_d[bit_cnt_q] = vote;
                    if (bit_cnt_q == last_bit) state_d = par_en ? PARITY : STOP;
                    else                       bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PARITY: begin
                if (decide) begin
                    pe_d    = (vote != par_calc);
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave at the stop-bit midpoint so a start edge right at the bit end is caught.
                if (decide) begin
                    push_req = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_baud) presc_d = 12'd0;
        if (!rxen || rx_disable) begin
            state_d  = IDLE;
            push_req = 1'b0;
        end
    end

    assign entry   = {shreg_q, ~vote, pe_q};
    assign push_ok = push_req & ((count_q != 3'd4) | pop);
    assign dor_set = push_req & (count_q == 3'd4) & ~pop;
    assign head    = fifo_q[rd_ptr_q];

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state_q   <= IDLE;
            ctrl_q    <= 8'd0;
            ubrr_q    <= 12'd0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            presc_q   <= 12'd0;
            os_q      <= 4'd0;
            samp_q    <= 2'b00;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'd0;
            pe_q      <= 1'b0;
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            dor_q     <= 1'b0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= 10'd0;
        end else begin
            rx_s1_q   <= RxDn_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            state_q   <= state_d;
            presc_q   <= presc_d;
            os_q      <= os_d;
            samp_q    <= samp_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            pe_q      <= pe_d;

            if (wr_ctrl)             ctrl_q        <= {dbus_in[7:4], 1'b0, dbus_in[2:1], 1'b0};
            if (ramwe && sel_baudl)  ubrr_q[7:0]   <= dbus_in;
            if (ramwe && sel_baudh)  ubrr_q[11:8]  <= dbus_in[3:0];

            if (rx_disable) begin
                wr_ptr_q <= 2'd0;
                rd_ptr_q <= 2'd0;
                count_q  <= 3'd0;
                dor_q    <= 1'b0;
            end else begin
                if (push_ok) begin
                    fifo_q[wr_ptr_q] <= entry;
                    wr_ptr_q         <= wr_ptr_q + 2'd1;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
                case ({push_ok, pop})
                    2'b10:   count_q <= count_q + 3'd1;
                    2'b01:   count_q <= count_q - 3'd1;
                    default: count_q <= count_q;
                endcase
                if (dor_set)                          dor_q <= 1'b1;
                else if (rd_data || (wr_stat && dbus_in[4])) dor_q <= 1'b0;
            end
        end
    end

    always_comb begin
        dbus_out = 8'd0;
        if (sel_data)  dbus_out = nonempty ? head[9:2] : 8'd0;
        if (sel_stat)  dbus_out = {nonempty, nonempty & head[1], nonempty & head[0], dor_q, 1'b0, count_q};
        if (sel_ctrl)  dbus_out = ctrl_q;
        if (sel_baudl) dbus_out = ubrr_q[7:0];
        if (sel_baudh) dbus_out = {4'd0, ubrr_q[11:8]};
    end

    assign out_en = ramre & (sel_data | sel_stat | sel_ctrl | sel_baudl | sel_baudh);
    assign RxcIRQ = ctrl_q[6] & nonempty;

endmodule

// File: tb/tb_usart_rx_monitor.sv
// Directed bench: serial frames driven at 64 cycles/bit, expected FIFO entries held in a scoreboard queue.
module tb_usart_rx_monitor;

    localparam logic [11:0] A_DATA  = 12'h0D0;
    localparam logic [11:0] A_STAT  = 12'h0D1;
    localparam logic [11:0] A_CTRL  = 12'h0D2;
    localparam logic [11:0] A_BAUDL = 12'h0D4;
    localparam logic [11:0] A_BAUDH = 12'h0D5;
    localparam int BITC = 64;

    logic        cp2, ireset, ramre, ramwe, RxDn_i;
    logic [11:0] ram_Addr;
    logic [7:0]  dbus_in, dbus_out;
    logic        out_en, RxcIRQ;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] exp_q [$];
    logic       m_dor = 1'b0;
    logic       m_rxcie = 1'b0;
    logic [7:0] rd_v;
    logic       oe_v;

    usart_rx_monitor dut (
        .cp2(cp2), .ireset(ireset), .ram_Addr(ram_Addr), .ramre(ramre), .ramwe(ramwe),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en), .RxDn_i(RxDn_i), .RxcIRQ(RxcIRQ)
    );

    initial cp2 = 1'b0;
    always #5 cp2 = ~cp2;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
        @(posedge cp2); #1;
        ram_Addr = a; dbus_in = d; ramwe = 1'b1;
        @(posedge cp2); #1;
        ramwe = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [7:0] d, output logic oe);
        @(posedge cp2); #1;
        ram_Addr = a; ramre = 1'b1;
        @(negedge cp2);
        d  = dbus_out;
        oe = out_en;
        @(posedge cp2); #1;
        ramre = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        RxDn_i = b;
        repeat (BITC) @(posedge cp2);
    endtask

    task automatic idle_bits(input int n);
        RxDn_i = 1'b1;
        repeat (n * BITC) @(posedge cp2);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input int pmode,
                              input logic bad_par, input logic stop_v);
        logic [7:0] dm;
        logic       p;
        dm = 8'd0;
        for (int i = 0; i < nbits; i++) dm[i] = d[i];
        p = ^dm;
        if (pmode == 2) p = ~p;
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(dm[i]);
        if (pmode != 0) drive_bit(p ^ bad_par);
        drive_bit(stop_v);
        if (exp_q.size() < 4) exp_q.push_back({dm, ~stop_v, (pmode != 0) & bad_par});
        else                  m_dor = 1'b1;
    endtask

    function automatic logic [7:0] exp_stat();
        int sz;
        sz = exp_q.size();
        if (sz == 0) return {3'b000, m_dor, 4'd0};
        return {1'b1, exp_q[0][1], exp_q[0][0], m_dor, 1'b0, 3'(sz)};
    endfunction

    task automatic check_stat(input string tag);
        logic [7:0] expv;
        expv = exp_stat();
        bus_read(A_STAT, rd_v, oe_v);
        check(tag, rd_v, expv);
        check({tag, "_irq"}, {7'd0, RxcIRQ}, {7'd0, m_rxcie & (exp_q.size() != 0)});
    endtask

    task automatic read_data(input string tag);
        logic [7:0] expv;
        expv = 8'd0;
        if (exp_q.size() != 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            expv = e[9:2];
        end
        m_dor = 1'b0;
        bus_read(A_DATA, rd_v, oe_v);
        check(tag, rd_v, expv);
    endtask

    initial begin
        ireset = 1'b0; ramre = 1'b0; ramwe = 1'b0; RxDn_i = 1'b1;
        ram_Addr = 12'd0; dbus_in = 8'd0;
        repeat (4) @(posedge cp2);
        #1;
        check("rst_dbus", dbus_out, 8'h00);
        check("rst_oe", {7'd0, out_en}, 8'h00);
        check("rst_irq", {7'd0, RxcIRQ}, 8'h00);
        ireset = 1'b1;
        bus_read(A_STAT, rd_v, oe_v);
        check("rst_stat", rd_v, 8'h00);
        check("oe_sel", {7'd0, oe_v}, 8'h01);
        bus_read(A_CTRL, rd_v, oe_v);
        check("rst_ctrl", rd_v, 8'h00);
        bus_read(12'h0D3, rd_v, oe_v);
        check("unsel_dbus", rd_v, 8'h00);
        check("unsel_oe", {7'd0, oe_v}, 8'h00);

        bus_write(A_BAUDL, 8'h03);
        bus_write(A_BAUDH, 8'h00);
        bus_write(A_CTRL, 8'hC6);
        m_rxcie = 1'b1;
        bus_read(A_BAUDL, rd_v, oe_v);
        check("baudl", rd_v, 8'h03);
        bus_read(A_CTRL, rd_v, oe_v);
        check("ctrl_rb", rd_v, 8'hC6);

        // 8N1 basic frame
        send_frame(8'h65, 8, 0, 1'b0, 1'b1);
        idle_bits(1);
        check("irq_65", {7'd0, RxcIRQ}, 8'h01);
        check_stat("stat_65");
        check("stat_65_lit", rd_v, 8'h81);
        read_data("data_65");
        check_stat("stat_65_empty");
        read_data("data_empty");

        // even parity: wrong parity bit, then framing error
        bus_write(A_CTRL, 8'hA6);
        m_rxcie = 1'b0;
        send_frame(8'h75, 8, 1, 1'b1, 1'b1);
        idle_bits(1);
        check_stat("stat_pe");
        check("stat_pe_lit", rd_v, 8'hA1);
        read_data("data_pe");
        send_frame(8'h75, 8, 1, 1'b0, 1'b0);
        idle_bits(2);
        check_stat("stat_fe");
        read_data("data_fe");

        // overrun: five back-to-back frames
        bus_write(A_CTRL, 8'hC6);
        m_rxcie = 1'b1;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 0, 1'b0, 1'b1);
        idle_bits(1);
        check_stat("stat_ovr");
        check("stat_ovr_lit", rd_v, 8'h94);
        read_data("ovr_rd1");
        check_stat("stat_dor_clr");
        for (int i = 2; i <= 4; i++) read_data("ovr_rd");
        check_stat("stat_drained");

        // quarter-bit glitch, then a valid frame
        RxDn_i = 1'b0;
        repeat (BITC / 4) @(posedge cp2);
        idle_bits(2);
        check_stat("stat_glitch");
        send_frame(8'hA5, 8, 0, 1'b0, 1'b1);
        idle_bits(1);
        check_stat("stat_a5");
        read_data("data_a5");

        // 5-bit characters
        bus_write(A_CTRL, 8'hC0);
        send_frame(8'h16, 5, 0, 1'b0, 1'b1);
        idle_bits(1);
        check_stat("stat_5b");
        read_data("data_5b");

        // disable mid-frame with two entries queued
        bus_write(A_CTRL, 8'hC6);
        send_frame(8'h11, 8, 0, 1'b0, 1'b1);
        send_frame(8'h22, 8, 0, 1'b0, 1'b1);
        idle_bits(1);
        check_stat("stat_two");
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        bus_write(A_CTRL, 8'h00);
        exp_q.delete();
        m_dor = 1'b0;
        m_rxcie = 1'b0;
        idle_bits(10);
        check_stat("stat_flush");
        check("irq_flush", {7'd0, RxcIRQ}, 8'h00);
        bus_write(A_CTRL, 8'hC6);
        m_rxcie = 1'b1;
        send_frame(8'h3C, 8, 0, 1'b0, 1'b1);
        idle_bits(1);
        check_stat("stat_reen");
        read_data("data_reen");
        check_stat("stat_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
